// File: rtl/uart_rfifo_gen_pkg.sv
// Purpose : shared constants and helpers for the parametrised UART receive FIFO.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: clog2 helper, trigger-select encodings, error-flag bit positions.
package uart_fifo_pkg;

  // trig_sel encodings: 1 entry, quarter, half, nearly full (DEPTH-2)
  localparam logic [1:0] TRIG_1  = 2'b00;
  localparam logic [1:0] TRIG_Q  = 2'b01;
  localparam logic [1:0] TRIG_H  = 2'b10;
  localparam logic [1:0] TRIG_NF = 2'b11;

  // Bit positions inside the per-character error field
  localparam int ERR_PAR = 0;
  localparam int ERR_FRM = 1;
  localparam int ERR_BRK = 2;

  // Ceiling log2, usable in parameter defaults
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_rfifo_gen_if.sv
// Purpose : bundles the receive-FIFO push/pop/status signals between receiver core and register decode.
// Latency : n/a (wiring only).
// Backpressure: push is dropped when full without a coincident pop (flagged by overrun).
// Ports   : master drives push/pop/data_in/fifo_reset/reset_status/trig_sel; slave (the FIFO) drives the status/data outputs.
interface uart_rfifo_gen_if
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ERR_W  = 3,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = clog2(DEPTH)
);
  logic                    push;
  logic                    pop;
  logic [DATA_W+ERR_W-1:0] data_in;
  logic                    fifo_reset;
  logic                    reset_status;
  logic [1:0]              trig_sel;
  logic [DATA_W+ERR_W-1:0] data_out;
  logic [PTR_W:0]          count;
  logic                    empty;
  logic                    full;
  logic                    trig_hit;
  logic                    overrun;
  logic [PTR_W:0]          err_count;
  logic                    error_bit;

  modport master (
    output push, pop, data_in, fifo_reset, reset_status, trig_sel,
    input  data_out, count, empty, full, trig_hit, overrun, err_count, error_bit
  );

  modport slave (
    input  push, pop, data_in, fifo_reset, reset_status, trig_sel,
    output data_out, count, empty, full, trig_hit, overrun, err_count, error_bit
  );
endinterface

// File: rtl/uart_rfifo_gen_ram.sv
// Purpose : single-write, asynchronous-read storage array for FIFO entries {char, err}.
// Latency : write visible on the read port right after the writing clock edge; read is combinational.
// Backpressure: none; the caller gates i_we.
// Ports   : clk; i_we/i_waddr/i_wdata write port; i_raddr/o_rdata read port.
module uart_fifo_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 11,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  // Contents are deliberately not reset; the top masks unread locations.
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_rfifo_gen.sv
// Purpose : parametrised UART receive FIFO with occupancy, trigger, overrun and error-in-FIFO status.
// Latency : push/pop reflected on data_out/count/err_count immediately after the clock edge (show-ahead).
// Backpressure: push while full is dropped unless popped in the same cycle; a drop sets sticky overrun.
// Ports   : clk, wb_rst_i (sync, active-high); bus (slave modport) carries push/pop/data and all status.
module uart_rfifo_gen
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ERR_W  = 3,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            wb_rst_i,
  uart_rfifo_gen_if.slave bus
);
  localparam int              W        = DATA_W + ERR_W;
  localparam logic [PTR_W:0]  CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0] r_top;
  logic [PTR_W-1:0] r_bottom;
  logic [PTR_W:0]   r_count;
  logic [PTR_W:0]   r_err_cnt;
  logic             r_overrun;

  logic             w_empty;
  logic             w_full;
  logic             w_flush;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_push_err;
  logic             w_pop_err;
  logic             w_ovr_set;
  logic             w_we;
  logic [W-1:0]     w_head;
  logic [PTR_W:0]   w_trig_lvl;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);
  assign w_flush = wb_rst_i | bus.fifo_reset;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop_ok   = bus.pop & ~w_empty;
  assign w_push_ok  = bus.push & (~w_full | bus.pop);
  assign w_push_err = w_push_ok & (|bus.data_in[ERR_W-1:0]);
  assign w_pop_err  = w_pop_ok & (|w_head[ERR_W-1:0]);
  assign w_ovr_set  = bus.push & w_full & ~bus.pop;
  assign w_we       = w_push_ok & ~w_flush;

  uart_fifo_ram #(
    .ADDR_W (PTR_W),
    .DATA_W (W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_top),
    .i_wdata (bus.data_in),
    .i_raddr (r_bottom),
    .o_rdata (w_head)
  );

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_top     <= '0;
      r_bottom  <= '0;
      r_count   <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_push_ok) r_top    <= r_top + PTR_ONE;
      if (w_pop_ok)  r_bottom <= r_bottom + PTR_ONE;
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + CNT_ONE;
      else if (!w_push_ok && w_pop_ok) r_count <= r_count - CNT_ONE;
      // Error entries arriving and leaving together cancel out.
      if (w_push_err && !w_pop_err)      r_err_cnt <= r_err_cnt + CNT_ONE;
      else if (!w_push_err && w_pop_err) r_err_cnt <= r_err_cnt - CNT_ONE;
    end
  end

  // Clear beats set, so a drop coincident with a status clear is not recorded.
  always_ff @(posedge clk) begin
    if (wb_rst_i)                               r_overrun <= 1'b0;
    else if (bus.fifo_reset | bus.reset_status) r_overrun <= 1'b0;
    else if (w_ovr_set)                         r_overrun <= 1'b1;
  end

  always_comb begin
    w_trig_lvl = CNT_ONE;
    case (bus.trig_sel)
      TRIG_1:  w_trig_lvl = CNT_ONE;
      TRIG_Q:  w_trig_lvl = (PTR_W+1)'(DEPTH / 4);
      TRIG_H:  w_trig_lvl = (PTR_W+1)'(DEPTH / 2);
      TRIG_NF: w_trig_lvl = (PTR_W+1)'(DEPTH - 2);
      default: w_trig_lvl = CNT_ONE;
    endcase
  end

  // Stale RAM words are never exposed: an empty FIFO reads as zero.
  assign bus.data_out  = w_empty ? '0 : w_head;
  assign bus.count     = r_count;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.trig_hit  = (r_count >= w_trig_lvl);
  assign bus.overrun   = r_overrun;
  assign bus.err_count = r_err_cnt;
  assign bus.error_bit = (r_err_cnt != '0);
endmodule
